muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer for the execute stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU operations from E, runs a 2-cycle multiplier or a 32-iteration restoring divider, and raises `busyE`. The hazard unit consumes `busyE` as its "mul/div computing" stall, freezing the pipeline until the result is ready. The 64-bit result is held in DONE until the pipeline accepts it, and exception flushes cancel an operation in flight.

---
 rtl/muldiv_ctrl.sv | 176 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle multiply/divide sequencer for the MIPS execute stage.
// Runs MULT/MULTU in a 2-cycle multiplier path and DIV/DIVU as a restoring
// shift-subtract divider producing one quotient bit per cycle. The 64-bit
// result is held in DONE until the pipeline accepts it.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset (aborts op, clears outputs)
//   startE       E-stage instruction is a mul/div op
//   opE[1:0]     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcaE[31:0]  rs operand (multiplicand / dividend)
//   srcbE[31:0]  rt operand (multiplier / divisor)
//   cancel       exception flush of E; aborts any operation
//   stallIn      pipeline stall; result held in DONE while high
//   busyE        operation in progress (combinational in the start cycle)
//   resultValid  hiOut/loOut hold the E-stage instruction's result
//   hiOut[31:0]  product[63:32] or remainder
//   loOut[31:0]  product[31:0] or quotient
module muldiv_ctrl #(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startE,
    input  logic [1:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        cancel,
    input  logic        stallIn,
    output logic        busyE,
    output logic        resultValid,
    output logic [31:0] hiOut,
    output logic [31:0] loOut
);

    localparam int unsigned CW = $clog2(DIV_ITER + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(DIV_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_signed;   // MULT: sign-extend operands
    logic [31:0]   r_a;        // raw srcaE, kept for the divide-by-zero HI value
    logic [31:0]   r_b;        // multiplier, or divisor magnitude
    logic [31:0]   r_rem;
    logic [31:0]   r_quo;      // dividend shifts out as quotient bits shift in
    logic          r_negq;
    logic          r_negr;
    logic          r_dvz;
    logic [CW-1:0] r_cnt;
    logic          r_valid;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    // Operand magnitudes for signed divide
    logic        w_sdiv;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;

    assign w_sdiv  = opE[1] & ~opE[0];
    assign w_abs_a = (w_sdiv & srcaE[31]) ? (~srcaE + 32'd1) : srcaE;
    assign w_abs_b = (w_sdiv & srcbE[31]) ? (~srcbE + 32'd1) : srcbE;

    // Single 64x64 multiply on extended operands covers signed and unsigned
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;

    assign w_ext_a = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    assign w_ext_b = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // One restoring-divide iteration; bit 33 of the difference is the borrow
    logic [32:0] w_shift;
    logic [33:0] w_diff;
    logic        w_borrow;
    logic [31:0] w_rem_n;
    logic [31:0] w_quo_n;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign w_shift  = {r_rem, r_quo[31]};
    assign w_diff   = {1'b0, w_shift} - {2'b00, r_b};
    assign w_borrow = w_diff[33];
    assign w_rem_n  = w_borrow ? w_shift[31:0] : w_diff[31:0];
    assign w_quo_n  = {r_quo[30:0], ~w_borrow};
    assign w_q_fix  = r_negq ? (~w_quo_n + 32'd1) : w_quo_n;
    assign w_r_fix  = r_negr ? (~w_rem_n + 32'd1) : w_rem_n;

    // Combinational in IDLE so the pipeline freezes in the start cycle
    assign busyE = ((r_state == S_IDLE) & startE & ~cancel)
                 | (r_state == S_MUL) | (r_state == S_DIV);

    assign resultValid = r_valid;
    assign hiOut       = r_hi;
    assign loOut       = r_lo;

    // Sequencer FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_signed <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_dvz    <= 1'b0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (cancel) begin
            // Abort: outputs keep the last committed result
            r_state <= S_IDLE;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (startE) begin
                        r_signed <= ~opE[0];
                        r_a      <= srcaE;
                        r_b      <= opE[1] ? w_abs_b : srcbE;
                        r_quo    <= w_abs_a;
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_negq   <= w_sdiv & (srcaE[31] ^ srcbE[31]);
                        r_negr   <= w_sdiv & srcaE[31];
                        r_dvz    <= (srcbE == 32'd0);
                        r_state  <= opE[1] ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    r_hi    <= w_prod[63:32];
                    r_lo    <= w_prod[31:0];
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DIV: begin
                    r_rem <= w_rem_n;
                    r_quo <= w_quo_n;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        // Divide by zero bypasses the sign fix entirely
                        if (r_dvz) begin
                            r_hi <= r_a;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_r_fix;
                            r_lo <= w_q_fix;
                        end
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // startE ignored here: the finished instruction is still in E
                    if (!stallIn) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        cancel;
    logic        stallIn;
    logic        busyE;
    logic        resultValid;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl #(.DIV_ITER(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .startE      (startE),
        .opE         (opE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .cancel      (cancel),
        .stallIn     (stallIn),
        .busyE       (busyE),
        .resultValid (resultValid),
        .hiOut       (hiOut),
        .loOut       (loOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; land 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a mul/div op in E for the current cycle
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        #1;
    endtask

    // Wait (bounded) for resultValid; counts busy cycles seen on the way
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (resultValid) begin
                lat = i;
                return;
            end
            if (busyE) busy_cnt++;
            cyc();
        end
    endtask

    // Instruction leaves E; FSM should be back in IDLE
    task automatic leave_e();
        startE = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
        cancel = 1'b0; stallIn = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busyE); end
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resultValid); end
        checks++; if (hiOut !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=00000000", hiOut); end
        checks++; if (loOut !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=00000000", loOut); end
        cyc();
    endtask

    task automatic test_mult();
        int lat, bc;
        start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        checks++; if (busyE !== 1'b1) begin errors++; $display("FAIL mult_busy_start got=%b exp=1", busyE); end
        wait_done(lat, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mult_latency got=%0d exp=2", lat); end
        checks++; if (bc !== 2) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=2", bc); end
        checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL mult_busy_done got=%b exp=0", busyE); end
        checks++; if (hiOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hiOut); end
        checks++; if (loOut !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got=%h exp=fffffff1", loOut); end
        leave_e();
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL mult_idle_valid got=%b exp=0", resultValid); end
    endtask

    task automatic test_div();
        int lat, bc;
        start_op(2'b11, 32'd100, 32'd7);
        wait_done(lat, bc);
        checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency got=%0d exp=33", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL divu_busy_cycles got=%0d exp=33", bc); end
        checks++; if (loOut !== 32'd14) begin errors++; $display("FAIL divu_lo got=%h exp=0000000e", loOut); end
        checks++; if (hiOut !== 32'd2) begin errors++; $display("FAIL divu_hi got=%h exp=00000002", hiOut); end
        leave_e();
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, bc);
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_neg_latency got=%0d exp=33", lat); end
        checks++; if (loOut !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got=%h exp=fffffffd", loOut); end
        checks++; if (hiOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got=%h exp=ffffffff", hiOut); end
        leave_e();
    endtask

    task automatic test_div_zero();
        int lat, bc;
        start_op(2'b10, 32'd5, 32'd0);
        wait_done(lat, bc);
        checks++; if (lat !== 33) begin errors++; $display("FAIL dvz_latency got=%0d exp=33", lat); end
        checks++; if (loOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dvz_lo got=%h exp=ffffffff", loOut); end
        checks++; if (hiOut !== 32'd5) begin errors++; $display("FAIL dvz_hi got=%h exp=00000005", hiOut); end
        leave_e();
        // Negative dividend: HI is the raw operand, no sign fix
        start_op(2'b10, 32'hFFFF_FFF8, 32'd0);
        wait_done(lat, bc);
        checks++; if (loOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dvz_neg_lo got=%h exp=ffffffff", loOut); end
        checks++; if (hiOut !== 32'hFFFF_FFF8) begin errors++; $display("FAIL dvz_neg_hi got=%h exp=fffffff8", hiOut); end
        leave_e();
        start_op(2'b11, 32'hFFFF_FFF0, 32'd0);
        wait_done(lat, bc);
        checks++; if (loOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dvzu_lo got=%h exp=ffffffff", loOut); end
        checks++; if (hiOut !== 32'hFFFF_FFF0) begin errors++; $display("FAIL dvzu_hi got=%h exp=fffffff0", hiOut); end
        leave_e();
    endtask

    task automatic test_div_overflow();
        int lat, bc;
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, bc);
        checks++; if (loOut !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", loOut); end
        checks++; if (hiOut !== 32'h0) begin errors++; $display("FAIL div_ovf_hi got=%h exp=00000000", hiOut); end
        leave_e();
    endtask

    task automatic test_cancel();
        int lat, bc;
        int seen;
        // Previous committed result: 0x80000000 / -1 -> hi=0, lo=0x80000000
        start_op(2'b11, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) cyc();
        cancel = 1'b1;
        #1;
        cyc();
        cancel = 1'b0;
        startE = 1'b0;
        #1;
        checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL cancel_busy got=%b exp=0", busyE); end
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL cancel_valid got=%b exp=0", resultValid); end
        checks++; if (hiOut !== 32'h0) begin errors++; $display("FAIL cancel_hi_kept got=%h exp=00000000", hiOut); end
        checks++; if (loOut !== 32'h8000_0000) begin errors++; $display("FAIL cancel_lo_kept got=%h exp=80000000", loOut); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resultValid || busyE) seen++;
            cyc();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL cancel_no_activity got=%0d exp=0", seen); end
        start_op(2'b00, 32'd3, 32'd4);
        wait_done(lat, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL post_cancel_latency got=%0d exp=2", lat); end
        checks++; if (loOut !== 32'd12) begin errors++; $display("FAIL post_cancel_lo got=%h exp=0000000c", loOut); end
        checks++; if (hiOut !== 32'd0) begin errors++; $display("FAIL post_cancel_hi got=%h exp=00000000", hiOut); end
        leave_e();
        // cancel together with startE in IDLE: no start
        start_op(2'b00, 32'd9, 32'd9);
        cancel = 1'b1;
        #1;
        checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL cancel_start_busy got=%b exp=0", busyE); end
        cyc();
        cancel = 1'b0;
        startE = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (resultValid || busyE) seen++;
            cyc();
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL cancel_start_nostart got=%0d exp=0", seen); end
        checks++; if (loOut !== 32'd12) begin errors++; $display("FAIL cancel_start_lo_kept got=%h exp=0000000c", loOut); end
    endtask

    task automatic test_stall();
        int lat, bc;
        start_op(2'b00, 32'd6, 32'd7);
        wait_done(lat, bc);
        for (int k = 0; k < 4; k++) begin
            stallIn = (k < 3);
            #1;
            checks++; if (resultValid !== 1'b1) begin errors++; $display("FAIL stall_valid k=%0d got=%b exp=1", k, resultValid); end
            checks++; if (loOut !== 32'd42) begin errors++; $display("FAIL stall_lo k=%0d got=%h exp=0000002a", k, loOut); end
            checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL stall_busy k=%0d got=%b exp=0", k, busyE); end
            cyc();
        end
        startE = 1'b0;
        #1;
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL stall_release got=%b exp=0", resultValid); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        start_op(2'b11, 32'd9, 32'd3);
        wait_done(lat, bc);
        checks++; if (loOut !== 32'd3) begin errors++; $display("FAIL b2b_div_lo got=%h exp=00000003", loOut); end
        checks++; if (hiOut !== 32'd0) begin errors++; $display("FAIL b2b_div_hi got=%h exp=00000000", hiOut); end
        cyc();
        start_op(2'b01, 32'd2, 32'd3);
        checks++; if (busyE !== 1'b1) begin errors++; $display("FAIL b2b_mul_start got=%b exp=1", busyE); end
        wait_done(lat, bc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_mul_latency got=%0d exp=2", lat); end
        checks++; if (loOut !== 32'd6) begin errors++; $display("FAIL b2b_mul_lo got=%h exp=00000006", loOut); end
        checks++; if (hiOut !== 32'd0) begin errors++; $display("FAIL b2b_mul_hi got=%h exp=00000000", hiOut); end
    endtask

    task automatic test_reset_mid();
        // Still in DONE with lo=6; reset must clear the outputs
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        startE = 1'b0;
        #1;
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", resultValid); end
        checks++; if (loOut !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got=%h exp=00000000", loOut); end
        checks++; if (busyE !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busyE); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_div_overflow();
        test_cancel();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
